// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-client line-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    localparam int GNT_IDX_I = 0;
    localparam int GNT_IDX_D = 1;

endpackage

// File: rtl/mem_arbiter_2port_if.sv
// Cache-side, memory-side and status signals of the line-memory arbiter.
interface mem_arbiter_2port_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
);
    logic              i_mem_read_i;
    logic              i_mem_write_i;
    logic [ADDR_W-1:0] i_mem_addr_i;
    logic [DATA_W-1:0] i_mem_wdata_i;
    logic              i_mem_ready_o;
    logic              d_mem_read_i;
    logic              d_mem_write_i;
    logic [ADDR_W-1:0] d_mem_addr_i;
    logic [DATA_W-1:0] d_mem_wdata_i;
    logic              d_mem_ready_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [1:0]        grant_o;
    logic [CNT_W-1:0]  i_grant_cnt_o;
    logic [CNT_W-1:0]  d_grant_cnt_o;

    // Read data goes straight from memory to both caches, so the arbiter side never sees it.
    modport slave (
        input  i_mem_read_i, i_mem_write_i, i_mem_addr_i, i_mem_wdata_i,
        input  d_mem_read_i, d_mem_write_i, d_mem_addr_i, d_mem_wdata_i,
        input  mem_ready_i,
        output i_mem_ready_o, d_mem_ready_o,
        output mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        output grant_o, i_grant_cnt_o, d_grant_cnt_o
    );

    modport master (
        output i_mem_read_i, i_mem_write_i, i_mem_addr_i, i_mem_wdata_i,
        output d_mem_read_i, d_mem_write_i, d_mem_addr_i, d_mem_wdata_i,
        output mem_ready_i, mem_rdata_i,
        input  i_mem_ready_o, d_mem_ready_o,
        input  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o,
        input  grant_o, i_grant_cnt_o, d_grant_cnt_o
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for completed-transaction statistics.
// Latency: count visible the cycle after inc.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter_2port.sv
// Shares one line-wide memory port between I-cache and D-cache.
// Latency: 1 cycle request-to-memory; TURN + IDLE between back-to-back grants.
// Backpressure: clients hold until their ready; the loser sees ready = 0.
module mem_arbiter_2port
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 28,
    parameter int DATA_W       = 128,
    parameter int RR_MODE      = 0,
    parameter int STARVE_LIMIT = 15,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    mem_arbiter_2port_if.slave        bus
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              ptr_d_q, ptr_d_d;
    logic              i_req, d_req, pick_i;
    logic              i_inc, d_inc;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              i_rdy, d_rdy;
    logic [1:0]        grant;

    assign i_req = bus.i_mem_read_i | bus.i_mem_write_i;
    assign d_req = bus.d_mem_read_i | bus.d_mem_write_i;

    // ptr_d_q set means D wins the next round-robin tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
            ptr_d_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            ptr_d_q  <= ptr_d_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        ptr_d_d   = ptr_d_q;
        i_inc     = 1'b0;
        d_inc     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_rdy     = 1'b0;
        d_rdy     = 1'b0;
        grant     = 2'b00;
        pick_i    = i_req;
        if (i_req && d_req) begin
            pick_i = (RR_MODE != 0) ? !ptr_d_q : (starve_q >= STARVE_MAX);
        end

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = pick_i ? GNT_I : GNT_D;
                    if (RR_MODE == 0) begin
                        if (pick_i) begin
                            starve_d = '0;
                        end else if (i_req && (starve_q < STARVE_MAX)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end
            GNT_I: begin
                grant[GNT_IDX_I] = 1'b1;
                mem_read  = bus.i_mem_read_i;
                mem_write = bus.i_mem_write_i;
                mem_addr  = bus.i_mem_addr_i;
                mem_wdata = bus.i_mem_wdata_i;
                i_rdy     = bus.mem_ready_i;
                if (bus.mem_ready_i) begin
                    i_inc   = 1'b1;
                    ptr_d_d = !ptr_d_q;
                    state_d = TURN;
                end else if (!i_req) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                grant[GNT_IDX_D] = 1'b1;
                mem_read  = bus.d_mem_read_i;
                mem_write = bus.d_mem_write_i;
                mem_addr  = bus.d_mem_addr_i;
                mem_wdata = bus.d_mem_wdata_i;
                d_rdy     = bus.mem_ready_i;
                if (bus.mem_ready_i) begin
                    d_inc   = 1'b1;
                    ptr_d_d = !ptr_d_q;
                    state_d = TURN;
                end else if (!d_req) begin
                    state_d = IDLE;
                end
            end
            // Dead cycle lets the served cache drop its request before re-arbitration.
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_read_o    = mem_read;
    assign bus.mem_write_o   = mem_write;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_wdata_o   = mem_wdata;
    assign bus.i_mem_ready_o = i_rdy;
    assign bus.d_mem_ready_o = d_rdy;
    assign bus.grant_o       = grant;

    sat_counter #(.W(CNT_W)) u_i_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (i_inc),
        .cnt   (bus.i_grant_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_d_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (d_inc),
        .cnt   (bus.d_grant_cnt_o)
    );

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Scoreboard bench: instance 0 fixed priority (starve limit 3), instance 1 round-robin.
module tb_mem_arbiter_2port;

    localparam int LAT = 5;

    typedef struct packed {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wd;
    } req_t;

    typedef struct packed {
        logic [1:0]   gnt;
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] stray;

    req_t cq [4][$];
    exp_t eq [2][$];

    logic [1:0]  gnt   [2];
    logic        mrd   [2];
    logic        mwr   [2];
    logic [27:0] maddr [2];
    logic        irdy  [2];
    logic        drdy  [2];
    logic [15:0] icnt  [2];
    logic [15:0] dcnt  [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_h
        mem_arbiter_2port_if #(.ADDR_W(28), .DATA_W(128), .CNT_W(16)) bus ();

        mem_arbiter_2port #(
            .ADDR_W(28), .DATA_W(128), .RR_MODE(k), .STARVE_LIMIT(3), .CNT_W(16)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        logic         i_rd, i_wr, d_rd, d_wr, m_rdy;
        logic [27:0]  i_addr, d_addr;
        logic [127:0] i_wd, d_wd;
        int           mcnt;

        assign bus.i_mem_read_i  = i_rd;
        assign bus.i_mem_write_i = i_wr;
        assign bus.i_mem_addr_i  = i_addr;
        assign bus.i_mem_wdata_i = i_wd;
        assign bus.d_mem_read_i  = d_rd;
        assign bus.d_mem_write_i = d_wr;
        assign bus.d_mem_addr_i  = d_addr;
        assign bus.d_mem_wdata_i = d_wd;
        assign bus.mem_ready_i   = m_rdy;
        assign bus.mem_rdata_i   = '0;

        assign gnt[k]   = bus.grant_o;
        assign mrd[k]   = bus.mem_read_o;
        assign mwr[k]   = bus.mem_write_o;
        assign maddr[k] = bus.mem_addr_o;
        assign irdy[k]  = bus.i_mem_ready_o;
        assign drdy[k]  = bus.d_mem_ready_o;
        assign icnt[k]  = bus.i_grant_cnt_o;
        assign dcnt[k]  = bus.d_grant_cnt_o;

        // Memory model plus two caches that hold each queued request until ready.
        initial begin : drv
            logic i_done, d_done;
            req_t h;
            i_rd = 0; i_wr = 0; d_rd = 0; d_wr = 0; m_rdy = 0; mcnt = 0;
            i_addr = '0; d_addr = '0; i_wd = '0; d_wd = '0;
            forever begin
                @(negedge clk);
                i_done = bus.i_mem_ready_o;
                d_done = bus.d_mem_ready_o;
                @(posedge clk);
                #1;
                if (!rst_n || m_rdy) begin
                    m_rdy = 0;
                    mcnt  = 0;
                end else if (stray[k]) begin
                    m_rdy = 1;
                end else if (bus.mem_read_o || bus.mem_write_o) begin
                    mcnt++;
                    if (mcnt == LAT) m_rdy = 1;
                end else begin
                    mcnt = 0;
                end
                if (i_done && cq[2*k].size() > 0) void'(cq[2*k].pop_front());
                if (d_done && cq[2*k+1].size() > 0) void'(cq[2*k+1].pop_front());
                if (cq[2*k].size() > 0) begin
                    h = cq[2*k][0];
                    i_rd = !h.wr; i_wr = h.wr; i_addr = h.addr; i_wd = h.wd;
                end else begin
                    i_rd = 0; i_wr = 0;
                end
                if (cq[2*k+1].size() > 0) begin
                    h = cq[2*k+1][0];
                    d_rd = !h.wr; d_wr = h.wr; d_addr = h.addr; d_wd = h.wd;
                end else begin
                    d_rd = 0; d_wr = 0;
                end
            end
        end

        initial begin : mon
            exp_t a, e;
            forever begin
                @(negedge clk);
                if (rst_n && m_rdy && bus.grant_o != 2'b00) begin
                    a = {bus.grant_o, bus.mem_read_o, bus.mem_write_o, bus.mem_addr_o, bus.mem_wdata_o};
                    if (eq[k].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL sb_unexpected[%0d]: got %0h, expected no transaction", k, a);
                    end else begin
                        e = eq[k].pop_front();
                        chk($sformatf("sb_txn[%0d]", k), a, e);
                    end
                end
            end
        end
    end

    task automatic issue(input int k, input int c, input logic wr, input logic [27:0] addr,
                         input logic [127:0] wd);
        req_t r;
        r = '{wr: wr, addr: addr, wd: wd};
        cq[2*k+c].push_back(r);
    endtask

    task automatic expect_txn(input int k, input int c, input logic wr, input logic [27:0] addr,
                              input logic [127:0] wd);
        exp_t e;
        e = '{gnt: (c != 0) ? 2'b10 : 2'b01, rd: !wr, wr: wr, addr: addr, wd: wd};
        eq[k].push_back(e);
    endtask

    task automatic wait_gnt(input int k, input logic [1:0] g, input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (gnt[k] != g && n < 50);
        chk(nm, gnt[k], g);
    endtask

    task automatic wait_drdy(input int k, input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (!drdy[k] && n < 50);
        chk(nm, drdy[k], 1);
    endtask

    task automatic wait_empty(input int k, input string nm);
        int n = 0;
        while (eq[k].size() != 0 && n < 400) begin @(negedge clk); n++; end
        chk(nm, eq[k].size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int ip, dp;
        rst_n = 1'b0;
        stray = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_grant", gnt[0], 2'b00);
        chk("rst_mem_rw", {mrd[0], mwr[0]}, 2'b00);
        chk("rst_ready", {irdy[0], drdy[0]}, 2'b00);
        chk("rst_icnt", icnt[0], 0);
        chk("rst_dcnt", dcnt[0], 0);

        // Single I read.
        issue(0, 0, 1'b0, 28'h0000010, '0);
        expect_txn(0, 0, 1'b0, 28'h0000010, '0);
        @(negedge clk);
        chk("t1_arb_cycle_grant", gnt[0], 2'b00);
        @(negedge clk);
        chk("t1_grant", gnt[0], 2'b01);
        chk("t1_addr", maddr[0], 28'h0000010);
        chk("t1_rw", {mrd[0], mwr[0]}, 2'b10);
        ip = 0; dp = 0;
        repeat (6) begin
            @(negedge clk);
            ip += int'(irdy[0]);
            dp += int'(drdy[0]);
        end
        chk("t1_i_ready_pulses", ip, 1);
        chk("t1_d_ready_pulses", dp, 0);
        chk("t1_icnt", icnt[0], 1);
        chk("t1_idle_grant", gnt[0], 2'b00);

        // Simultaneous requests, fixed priority: D write first.
        issue(0, 1, 1'b1, 28'h0000ABC, {4{32'hDEADBEEF}});
        issue(0, 0, 1'b0, 28'h0000020, '0);
        expect_txn(0, 1, 1'b1, 28'h0000ABC, {4{32'hDEADBEEF}});
        expect_txn(0, 0, 1'b0, 28'h0000020, '0);
        wait_gnt(0, 2'b10, "t2_d_first");
        chk("t2_d_write", {mrd[0], mwr[0]}, 2'b01);
        wait_drdy(0, "t2_d_ready");
        @(negedge clk);
        chk("t2_turn_grant", gnt[0], 2'b00);
        @(negedge clk);
        chk("t2_idle_grant", gnt[0], 2'b00);
        @(negedge clk);
        chk("t2_i_after_gap", gnt[0], 2'b01);
        wait_empty(0, "t2_drain");

        // Starvation guard: I wins every 4th arbitration while D keeps requesting.
        for (int n = 0; n < 6; n++)
            issue(0, 1, n[0], 28'h0000100 + 28'(n), {4{32'hA5000000 + 32'(n)}});
        issue(0, 0, 1'b0, 28'h0000200, '0);
        issue(0, 0, 1'b0, 28'h0000201, '0);
        for (int n = 0; n < 3; n++)
            expect_txn(0, 1, n[0], 28'h0000100 + 28'(n), {4{32'hA5000000 + 32'(n)}});
        expect_txn(0, 0, 1'b0, 28'h0000200, '0);
        for (int n = 3; n < 6; n++)
            expect_txn(0, 1, n[0], 28'h0000100 + 28'(n), {4{32'hA5000000 + 32'(n)}});
        expect_txn(0, 0, 1'b0, 28'h0000201, '0);
        wait_empty(0, "t3_drain");
        chk("t3_icnt", icnt[0], 4);
        chk("t3_dcnt", dcnt[0], 7);

        // Stray memory ready while idle.
        stray[0] = 1'b1;
        ip = 0; dp = 0;
        repeat (3) begin
            @(negedge clk);
            stray[0] = 1'b0;
            ip += int'(irdy[0]);
            dp += int'(drdy[0]);
        end
        chk("t6_no_ready", ip + dp, 0);
        chk("t6_icnt", icnt[0], 4);
        chk("t6_dcnt", dcnt[0], 7);
        chk("t6_grant", gnt[0], 2'b00);

        // Reset while D is granted, before ready.
        issue(0, 1, 1'b0, 28'h0000300, {4{32'h00000300}});
        wait_gnt(0, 2'b10, "t5_d_granted");
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_rw", {mrd[0], mwr[0]}, 2'b00);
        chk("t5_async_grant", gnt[0], 2'b00);
        chk("t5_icnt", icnt[0], 0);
        chk("t5_dcnt", dcnt[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_txn(0, 1, 1'b0, 28'h0000300, {4{32'h00000300}});
        wait_empty(0, "t5_rearb");
        chk("t5_dcnt_after", dcnt[0], 1);
        chk("t5_icnt_after", icnt[0], 0);

        // Round-robin: D, I, D, I from a D-pointing reset pointer.
        issue(1, 0, 1'b0, 28'h0000400, '0);
        issue(1, 0, 1'b0, 28'h0000401, '0);
        issue(1, 1, 1'b1, 28'h0000500, {4{32'h0BADF00D}});
        issue(1, 1, 1'b0, 28'h0000501, '0);
        expect_txn(1, 1, 1'b1, 28'h0000500, {4{32'h0BADF00D}});
        expect_txn(1, 0, 1'b0, 28'h0000400, '0);
        expect_txn(1, 1, 1'b0, 28'h0000501, '0);
        expect_txn(1, 0, 1'b0, 28'h0000401, '0);
        wait_empty(1, "t4_drain");
        chk("t4_icnt", icnt[1], 2);
        chk("t4_dcnt", dcnt[1], 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2port.md
Name: mem_arbiter_2port

Overview:
- Shares the single 128-bit line-wide memory port between the instruction cache (client I) and the data cache (client D).
- Each cache keeps its native memory handshake: it holds read or write plus address until it sees ready.
- The arbiter picks one client, forwards that client's request, and routes ready back to it alone.
- Sits between both cache instances and the memory model at the top level. Priority policy is configurable, with a starvation guard.

Parameters:
ADDR_W, 28, line address width
DATA_W, 128, line data width
RR_MODE, 0, 0 = fixed priority (D over I); 1 = round-robin
STARVE_LIMIT, 15, in fixed mode, consecutive cycles a waiting I may be passed over before it is forced next
CNT_W, 16, width of the grant counters

Ports:
clk  in  1  clock
rst_n  in  1  reset
i_mem_read_i  in  1  I-cache read request
i_mem_write_i  in  1  I-cache write request
i_mem_addr_i  in  ADDR_W  I-cache line address
i_mem_wdata_i  in  DATA_W  I-cache write data
i_mem_ready_o  out  1  ready to I-cache
d_mem_read_i  in  1  D-cache read request
d_mem_write_i  in  1  D-cache write request
d_mem_addr_i  in  ADDR_W  D-cache line address
d_mem_wdata_i  in  DATA_W  D-cache write data
d_mem_ready_o  out  1  ready to D-cache
mem_rdata_i  in  DATA_W  memory read data, broadcast to both caches
mem_ready_i  in  1  memory completion pulse
mem_read_o  out  1  memory read
mem_write_o  out  1  memory write
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
grant_o  out  2  one-hot: bit0 = I, bit1 = D
i_grant_cnt_o  out  CNT_W  completed I transactions, saturating
d_grant_cnt_o  out  CNT_W  completed D transactions, saturating

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, port rst_n.
- Reset values:
  - state = IDLE; grant_o = 0.
  - All mem_*_o and *_ready_o = 0.
  - Both counters = 0; starvation counter = 0; round-robin pointer = D.
- A client requests when read_i or write_i is high.
- State IDLE:
  - No memory outputs are driven (all 0).
  - If any client requests, choose the winner and register the grant. Next state is GNT_I or GNT_D.
  - Arbitration latency is exactly 1 cycle from the request to the memory request.
- Winner selection:
  - Only one requester: that client wins.
  - Both request, RR_MODE = 0: D wins, unless the starvation counter is at or above STARVE_LIMIT, in which case I wins.
  - Both request, RR_MODE = 1: the client indicated by the pointer wins. The pointer flips to the other client on each completion.
- States GNT_I and GNT_D:
  - mem_read_o, mem_write_o, mem_addr_o and mem_wdata_o combinationally mirror the granted client's inputs. The other client is fully masked.
  - The granted client's *_ready_o = mem_ready_i; the other client's ready is 0.
  - On mem_ready_i: the granted counter increments, saturating at all-ones. Next state is TURN.
  - If the granted client drops both read and write before ready (abort): next state is IDLE, and the counter does not increment.
- State TURN:
  - One dead cycle with all outputs 0. This lets the served cache drop its request, so a stale request is never re-granted.
  - Next state is IDLE.
- Consequences: minimum spacing between back-to-back transactions is 2 cycles after ready. A D write-back followed by a D allocate is two separate grants.
- Starvation counter (fixed mode only):
  - Increments in each IDLE cycle in which I requests but D is granted.
  - Clears when I is granted; saturates at STARVE_LIMIT.
- mem_ready_i in IDLE or TURN is ignored: no ready is forwarded and no counter changes.
- Read and write both high from one client: both are forwarded unchanged. This is a client protocol violation; the arbiter does not resolve it.
- Reset asserted mid-transaction: the arbiter returns to reset values immediately. Memory outputs drop asynchronously.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding IDLE, GNT_I, GNT_D, TURN;
  - grant index constants GNT_IDX_I = 0 and GNT_IDX_D = 1.
- One natural sub-module, sat_counter (parameterised width, increment enable, asynchronous active-low clear). It is instantiated twice for the grant counters.

Test Plan:
- Only I reads addr 0x0000010; memory returns ready after 5 cycles.
  -> grant_o = 01 one cycle after the request; mem_addr_o = 0x0000010.
  -> i_mem_ready_o pulses once; d_mem_ready_o stays 0.
  -> i_grant_cnt_o = 1; TURN then IDLE follow.
- RR_MODE = 0; I and D request in the same cycle (D write, addr 0x0000ABC, wdata 0xDEADBEEF…).
  -> D is granted first; mem_write_o = 1 with D's data.
  -> I is granted 2 cycles after D's ready.
- RR_MODE = 0, STARVE_LIMIT = 3; D re-requests continuously while I waits.
  -> I is granted no later than the 4th arbitration.
  -> The starvation counter clears on I's grant.
- RR_MODE = 1; both clients request continuously for 4 transactions.
  -> Grants alternate D, I, D, I.
  -> Both counters = 2.
- Reset pulse (rst_n low) during GNT_D before ready.
  -> mem_read_o and mem_write_o drop asynchronously; grant_o = 00; counters = 0.
  -> After release, the held D request is re-arbitrated from IDLE.
- Stray mem_ready_i in IDLE.
  -> No *_ready_o pulse and no counter change.
